pe_alu_dispatch: RTL and testbench

PE_ALU_DISPATCH -- requirements
Module: pe_alu_dispatch

---
 rtl/pe_alu_pkg.sv | 17 +
 rtl/pe_operand_slot.sv | 37 +++
 rtl/pe_alu_dispatch.sv | 144 ++++++++++++++
 tb/tb_pe_alu_dispatch.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_alu_pkg.sv
// Shared opcode encoding and dispatcher FSM states for the PE ALU datapath.
package pe_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/pe_operand_slot.sv
// Single-entry valid/ready holding register for one ALU operand.
// Ready means the slot is empty; clear_i empties it once the operand has been consumed.
module pe_operand_slot
    import pe_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    input  logic             clear_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign ready_o = ~full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (valid_i && !full_q) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/pe_alu_dispatch.sv
// Collects two operands, issues them to an external ALU of latency LAT, holds the result
// until accepted. Define ALU_DISPATCH_ACC_EN to add the accumulate mode (acc_mode/acc_clear).
module pe_alu_dispatch
    import pe_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic [2:0]       op_func,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_func,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    input  logic             res_ready,
    output logic             busy
`ifdef ALU_DISPATCH_ACC_EN
    ,
    input  logic             acc_mode,
    input  logic             acc_clear
`endif
);

    localparam logic [1:0] LAT_CNT = 2'(LAT);

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic [2:0]       func_q;
    logic [WIDTH-1:0] res_q;

    logic [1:0]       in_valid;
    logic [1:0]       slot_ready;
    logic [1:0]       slot_full;
    logic [1:0]       slot_fire;
    logic [WIDTH-1:0] in_data   [2];
    logic [WIDTH-1:0] slot_data [2];
    logic [WIDTH-1:0] op1;
    logic             use_acc;
    logic             a_avail;
    logic             b_avail;
    logic             issue_last;

`ifdef ALU_DISPATCH_ACC_EN
    logic [WIDTH-1:0] acc_q;

    assign use_acc = acc_mode;
    assign op1     = acc_mode ? acc_q : slot_data[0];

    // A clear request beats a result landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (acc_clear) begin
            acc_q <= '0;
        end else if (issue_last && acc_mode) begin
            acc_q <= alu_out;
        end
    end
`else
    assign use_acc = 1'b0;
    assign op1     = slot_data[0];
`endif

    assign in_valid   = {b_valid, a_valid & ~use_acc};
    assign in_data[0] = a_data;
    assign in_data[1] = b_data;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        pe_operand_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst),
            .valid_i(in_valid[gi]),
            .data_i (in_data[gi]),
            .ready_o(slot_ready[gi]),
            .clear_i(issue_last),
            .full_o (slot_full[gi]),
            .data_o (slot_data[gi])
        );
    end

    assign slot_fire = in_valid & slot_ready;
    assign a_ready   = slot_ready[0] & ~use_acc;
    assign b_ready   = slot_ready[1];

    // Count an operand accepted this cycle as present so issue starts the very next cycle.
    assign a_avail    = use_acc | slot_full[0] | slot_fire[0];
    assign b_avail    = slot_full[1] | slot_fire[1];
    assign issue_last = (state_q == ST_ISSUE) && (cnt_q == LAT_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            func_q  <= 3'd0;
            res_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (a_avail && b_avail) begin
                        state_q <= ST_ISSUE;
                        func_q  <= op_func;
                        cnt_q   <= 2'd0;
                    end
                end
                ST_ISSUE: begin
                    if (issue_last) begin
                        res_q   <= alu_out;
                        cnt_q   <= 2'd0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_en    = (state_q == ST_ISSUE);
    assign alu_in1   = alu_en ? op1 : '0;
    assign alu_in2   = alu_en ? slot_data[1] : '0;
    assign alu_func  = func_q;
    assign res_valid = (state_q == ST_HOLD);
    assign res_data  = res_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_alu_dispatch.sv
// Bench for pe_alu_dispatch: instance 0 runs LAT=0, instance 1 runs LAT=1, each with its own ALU model.
module tb_pe_alu_dispatch;
    import pe_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid   [2];
    logic        b_valid   [2];
    logic        a_ready   [2];
    logic        b_ready   [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic        alu_en    [2];
    logic        busy      [2];
    logic [31:0] a_data    [2];
    logic [31:0] b_data    [2];
    logic [31:0] alu_in1   [2];
    logic [31:0] alu_in2   [2];
    logic [31:0] alu_out   [2];
    logic [31:0] res_data  [2];
    logic [2:0]  op_func   [2];
    logic [2:0]  alu_func  [2];
`ifdef ALU_DISPATCH_ACC_EN
    logic        acc_mode  [2];
    logic        acc_clear [2];
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_XOR: return x ^ y;
            ALU_MUL: return x * y;
            default: return 32'd0;
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        pe_alu_dispatch #(
            .WIDTH(32),
            .LAT  (gi)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .a_valid  (a_valid[gi]),
            .a_data   (a_data[gi]),
            .a_ready  (a_ready[gi]),
            .b_valid  (b_valid[gi]),
            .b_data   (b_data[gi]),
            .b_ready  (b_ready[gi]),
            .op_func  (op_func[gi]),
            .alu_in1  (alu_in1[gi]),
            .alu_in2  (alu_in2[gi]),
            .alu_func (alu_func[gi]),
            .alu_en   (alu_en[gi]),
            .alu_out  (alu_out[gi]),
            .res_valid(res_valid[gi]),
            .res_data (res_data[gi]),
            .res_ready(res_ready[gi]),
            .busy     (busy[gi])
`ifdef ALU_DISPATCH_ACC_EN
            ,
            .acc_mode (acc_mode[gi]),
            .acc_clear(acc_clear[gi])
`endif
        );
        // Idle ALU output is a poison value so a capture at the wrong cycle shows up.
        if (gi == 0) begin : g_comb_alu
            assign alu_out[gi] = alu_en[gi] ? alu_ref(alu_func[gi], alu_in1[gi], alu_in2[gi]) : 32'hDEAD_BEEF;
        end else begin : g_reg_alu
            logic [31:0] alu_pipe;
            always @(posedge clk)
                alu_pipe <= alu_en[gi] ? alu_ref(alu_func[gi], alu_in1[gi], alu_in2[gi]) : 32'hDEAD_BEEF;
            assign alu_out[gi] = alu_pipe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (a_ready[d] !== 1'b1 || b_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready d%0d: a_ready=%b b_ready=%b expected 1 1", d, a_ready[d], b_ready[d]);
            end
            checks++;
            if (res_valid[d] !== 1'b0 || busy[d] !== 1'b0 || alu_en[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_flags d%0d: res_valid=%b busy=%b alu_en=%b expected 0 0 0", d, res_valid[d], busy[d], alu_en[d]);
            end
            checks++;
            if (res_data[d] !== 32'd0) begin
                failures++;
                $display("FAIL reset_res_data d%0d: got %h expected 0", d, res_data[d]);
            end
            checks++;
            if (alu_func[d] !== 3'd0 || alu_in1[d] !== 32'd0 || alu_in2[d] !== 32'd0) begin
                failures++;
                $display("FAIL reset_alu d%0d: func=%0d in1=%h in2=%h expected 0 0 0", d, alu_func[d], alu_in1[d], alu_in2[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // LAT=0, ADD 5+7, both operands in cycle 0, result visible in cycle 2.
    task automatic test_add_lat0();
        op_func[0] = ALU_ADD; res_ready[0] = 1'b1;
        a_valid[0] = 1'b1; a_data[0] = 32'd5;
        b_valid[0] = 1'b1; b_data[0] = 32'd7;
        @(negedge clk);
        checks++;
        if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL add_ready c0: a_ready=%b b_ready=%b expected 1 1", a_ready[0], b_ready[0]);
        end
        tick();
        a_valid[0] = 1'b0; b_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_en[0] !== 1'b1 || alu_in1[0] !== 32'd5 || alu_in2[0] !== 32'd7 || alu_func[0] !== ALU_ADD || res_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL add_issue c1: en=%b in1=%0d in2=%0d func=%0d rv=%b expected 1 5 7 0 0", alu_en[0], alu_in1[0], alu_in2[0], alu_func[0], res_valid[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b1 || res_data[0] !== 32'd12) begin
            failures++;
            $display("FAIL add_result c2: res_valid=%b res_data=%0d expected 1 12", res_valid[0], res_data[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL add_done c3: res_valid=%b busy=%b expected 0 0", res_valid[0], busy[0]);
        end
        tick();
    endtask

    // LAT=1, SUB 3-10 with b four cycles late: only channel A stalls, result in cycle 7.
    task automatic test_sub_lat1();
        op_func[1] = ALU_SUB; res_ready[1] = 1'b1;
        a_valid[1] = 1'b1; a_data[1] = 32'd3;
        tick();
        a_valid[1] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                b_valid[1] = 1'b1; b_data[1] = 32'd10;
            end
            @(negedge clk);
            checks++;
            if (a_ready[1] !== 1'b0 || b_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
                failures++;
                $display("FAIL sub_stall c%0d: a_ready=%b b_ready=%b busy=%b expected 0 1 0", c, a_ready[1], b_ready[1], busy[1]);
            end
            tick();
        end
        b_valid[1] = 1'b0;
        for (int c = 5; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (alu_en[1] !== 1'b1 || res_valid[1] !== 1'b0) begin
                failures++;
                $display("FAIL sub_issue c%0d: alu_en=%b res_valid=%b expected 1 0", c, alu_en[1], res_valid[1]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (res_valid[1] !== 1'b1 || res_data[1] !== 32'hFFFF_FFF9) begin
            failures++;
            $display("FAIL sub_result c7: res_valid=%b res_data=%h expected 1 fffffff9", res_valid[1], res_data[1]);
        end
        tick();
    endtask

    // MUL 6*7 held for 5 cycles of back-pressure while the next operands queue up.
    task automatic test_mul_stall();
        op_func[0] = ALU_MUL; res_ready[0] = 1'b0;
        a_valid[0] = 1'b1; a_data[0] = 32'd6;
        b_valid[0] = 1'b1; b_data[0] = 32'd7;
        tick();
        a_valid[0] = 1'b0; b_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_en[0] !== 1'b1 || alu_func[0] !== ALU_MUL) begin
            failures++;
            $display("FAIL mul_issue: alu_en=%b alu_func=%0d expected 1 5", alu_en[0], alu_func[0]);
        end
        tick();
        a_valid[0] = 1'b1; a_data[0] = 32'd2;
        b_valid[0] = 1'b1; b_data[0] = 32'd9;
        op_func[0] = ALU_ADD;
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b1 || res_data[0] !== 32'd42 || a_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL mul_hold c2: res_valid=%b res_data=%0d a_ready=%b expected 1 42 1", res_valid[0], res_data[0], a_ready[0]);
        end
        tick();
        a_valid[0] = 1'b0; b_valid[0] = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid[0] !== 1'b1 || res_data[0] !== 32'd42 || alu_en[0] !== 1'b0 || a_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL mul_stall c%0d: rv=%b data=%0d en=%b a_ready=%b expected 1 42 0 0", c, res_valid[0], res_data[0], alu_en[0], a_ready[0]);
            end
            tick();
        end
        res_ready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b1 || res_data[0] !== 32'd42) begin
            failures++;
            $display("FAIL mul_handshake c7: res_valid=%b res_data=%0d expected 1 42", res_valid[0], res_data[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b0 || alu_en[0] !== 1'b0) begin
            failures++;
            $display("FAIL mul_idle c8: res_valid=%b alu_en=%b expected 0 0", res_valid[0], alu_en[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (alu_en[0] !== 1'b1 || alu_in1[0] !== 32'd2 || alu_in2[0] !== 32'd9 || alu_func[0] !== ALU_ADD) begin
            failures++;
            $display("FAIL mul_next_issue c9: en=%b in1=%0d in2=%0d func=%0d expected 1 2 9 0", alu_en[0], alu_in1[0], alu_in2[0], alu_func[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b1 || res_data[0] !== 32'd11) begin
            failures++;
            $display("FAIL mul_next_result c10: res_valid=%b res_data=%0d expected 1 11", res_valid[0], res_data[0]);
        end
        tick();
    endtask

    // op_func wiggles while LAT=1 ISSUE runs; the op sampled at issue must stick.
    task automatic test_func_toggle();
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        op_func[1] = ALU_XOR; res_ready[1] = 1'b1;
        a_valid[1] = 1'b1; a_data[1] = x;
        b_valid[1] = 1'b1; b_data[1] = y;
        tick();
        a_valid[1] = 1'b0; b_valid[1] = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            op_func[1] = (c == 1) ? ALU_AND : ALU_OR;
            @(negedge clk);
            checks++;
            if (alu_en[1] !== 1'b1 || alu_func[1] !== ALU_XOR) begin
                failures++;
                $display("FAIL toggle_func c%0d: alu_en=%b alu_func=%0d expected 1 4", c, alu_en[1], alu_func[1]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (res_valid[1] !== 1'b1 || res_data[1] !== (x ^ y)) begin
            failures++;
            $display("FAIL toggle_result: res_valid=%b res_data=%h expected 1 %h", res_valid[1], res_data[1], x ^ y);
        end
        tick();
    endtask

    // Reset pulled mid-ISSUE: outputs clear at once and the in-flight result never appears.
    task automatic test_reset_mid_issue();
        op_func[1] = ALU_ADD; res_ready[1] = 1'b1;
        a_valid[1] = 1'b1; a_data[1] = 32'd100;
        b_valid[1] = 1'b1; b_data[1] = 32'd23;
        tick();
        a_valid[1] = 1'b0; b_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_en[1] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_issue: alu_en=%b expected 1", alu_en[1]);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (alu_en[1] !== 1'b0 || busy[1] !== 1'b0 || alu_in1[1] !== 32'd0 || alu_in2[1] !== 32'd0 || alu_func[1] !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_async: en=%b busy=%b in1=%h in2=%h func=%0d expected 0 0 0 0 0", alu_en[1], busy[1], alu_in1[1], alu_in2[1], alu_func[1]);
        end
        checks++;
        if (a_ready[1] !== 1'b1 || b_ready[1] !== 1'b1 || res_valid[1] !== 1'b0 || res_data[1] !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_chan: a_ready=%b b_ready=%b rv=%b data=%h expected 1 1 0 0", a_ready[1], b_ready[1], res_valid[1], res_data[1]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_after c%0d: res_valid=%b busy=%b expected 0 0", c, res_valid[1], busy[1]);
            end
            tick();
        end
    endtask

`ifdef ALU_DISPATCH_ACC_EN
    // Accumulate: ADD over a b-only stream, then a clear coinciding with a capture.
    task automatic test_acc();
        logic [31:0] sum;
        logic [31:0] exp;
        sum = 32'd0;
        acc_mode[0] = 1'b1; op_func[0] = ALU_ADD; res_ready[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            b_valid[0] = 1'b1;
            b_data[0] = (i == 5) ? 32'd4 : 32'(i);
            tick();
            b_valid[0] = 1'b0;
            acc_clear[0] = (i == 4);
            @(negedge clk);
            checks++;
            if (a_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL acc_a_ready t%0d: a_ready=%b expected 0", i, a_ready[0]);
            end
            tick();
            acc_clear[0] = 1'b0;
            exp = sum + b_data[0];
            sum = (i == 4) ? 32'd0 : exp;
            @(negedge clk);
            checks++;
            if (res_valid[0] !== 1'b1 || res_data[0] !== exp) begin
                failures++;
                $display("FAIL acc_result t%0d: res_valid=%b res_data=%0d expected 1 %0d", i, res_valid[0], res_data[0], exp);
            end
            tick();
        end
        acc_mode[0] = 1'b0;
    endtask
`endif

    // Random single transactions: independent arrival delays, random back-pressure.
    task automatic test_random(input int d, input int n);
        for (int t = 0; t < n; t++) begin
            int          ad, bd, rs, last, seen;
            logic [2:0]  op;
            logic [31:0] av, bv, exp;
            op = 3'($urandom_range(0, 5));
            av = $urandom; bv = $urandom;
            if ($urandom_range(0, 4) == 0) bv = 32'hFFFF_FFFF;
            ad = $urandom_range(0, 3); bd = $urandom_range(0, 3); rs = $urandom_range(0, 3);
            exp = alu_ref(op, av, bv);
            last = (ad > bd) ? ad : bd;
            seen = -1;
            op_func[d] = op;
            res_ready[d] = (rs == 0);
            a_data[d] = av; b_data[d] = bv;
            for (int cyc = 0; cyc <= last + d + 8; cyc++) begin
                a_valid[d] = (cyc == ad);
                b_valid[d] = (cyc == bd);
                @(negedge clk);
                if (cyc == ad) begin
                    checks++;
                    if (a_ready[d] !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_a_ready d%0d t%0d: got %b expected 1", d, t, a_ready[d]);
                    end
                end
                if (cyc == bd) begin
                    checks++;
                    if (b_ready[d] !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_b_ready d%0d t%0d: got %b expected 1", d, t, b_ready[d]);
                    end
                end
                if (res_valid[d] === 1'b1) begin
                    seen = cyc;
                    break;
                end
                tick();
            end
            a_valid[d] = 1'b0; b_valid[d] = 1'b0;
            checks++;
            if (seen != last + d + 2 || res_data[d] !== exp) begin
                failures++;
                $display("FAIL rnd_result d%0d t%0d op%0d: cycle=%0d data=%h expected cycle=%0d data=%h", d, t, op, seen, res_data[d], last + d + 2, exp);
            end
            for (int k = 1; k <= rs; k++) begin
                tick();
                if (k == rs) res_ready[d] = 1'b1;
                @(negedge clk);
                checks++;
                if (res_valid[d] !== 1'b1 || res_data[d] !== exp) begin
                    failures++;
                    $display("FAIL rnd_hold d%0d t%0d k%0d: rv=%b data=%h expected 1 %h", d, t, k, res_valid[d], res_data[d], exp);
                end
            end
            tick();
            @(negedge clk);
            checks++;
            if (res_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL rnd_release d%0d t%0d: res_valid=%b busy=%b expected 0 0", d, t, res_valid[d], busy[d]);
            end
            $display("txn d%0d t%0d op=%0d a=%h b=%h res=%h lat=%0d stall=%0d", d, t, op, av, bv, res_data[d], seen, rs);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            a_valid[d] = 1'b0; b_valid[d] = 1'b0; res_ready[d] = 1'b0;
            a_data[d] = 32'd0; b_data[d] = 32'd0; op_func[d] = 3'd0;
`ifdef ALU_DISPATCH_ACC_EN
            acc_mode[d] = 1'b0; acc_clear[d] = 1'b0;
`endif
        end
        rst = 1'b0;
        test_reset();
        test_add_lat0();
        test_sub_lat1();
        test_mul_stall();
        test_func_toggle();
        test_reset_mid_issue();
`ifdef ALU_DISPATCH_ACC_EN
        test_acc();
`endif
        test_random(0, 25);
        test_random(1, 25);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
